// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg
//   Types and constants shared by the serial word receiver and its counter.
//   - rx_state_t     : receiver FSM states (IDLE / SHIFT / DONE)
//   - MSB_FIRST_MODE : LSB_FIRST parameter value, first bit lands in po[WIDTH-1]
//   - LSB_FIRST_MODE : LSB_FIRST parameter value, first bit lands in po[0]
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

    localparam int MSB_FIRST_MODE = 0;
    localparam int LSB_FIRST_MODE = 1;

endpackage

// File: rtl/bit_counter.sv
// bit_counter
//   Generic terminal-count counter. Counts enabled cycles from 0 up to MAX and
//   then holds at MAX until cleared, so it never wraps on its own.
//   Parameters: WIDTH (counter bits), MAX (terminal value, must fit in WIDTH)
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset, count -> 0
//     clr  - synchronous clear, count -> 0 (wins over en)
//     en   - advance the count by one
//     cnt  - current count
//     last - high while cnt == MAX
module bit_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !last) begin
            // saturate at MAX: the owner restarts the count with clr
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign last = (cnt == MAX_V);

endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Serial-to-parallel receiver. Collects WIDTH qualified serial bits into a
//   word (MSB- or LSB-first) and holds it on a valid/ready output until taken.
//   Parameters: WIDTH (>= 2), LSB_FIRST (0: first bit -> po[WIDTH-1],
//               1: first bit -> po[0])
//   Ports:
//     clk       - clock, rising edge
//     rst       - synchronous active-high reset, dominates everything
//     start     - begin/restart a frame (ignored while a word is pending
//                 unless out_ready transfers it in the same cycle)
//     ser_en    - qualifies serin
//     serin     - serial data bit
//     out_ready - downstream accepts po
//     po        - registered parallel word
//     out_valid - po holds a complete word
//     co        - single-cycle pulse on word completion
//     busy      - high while shifting a frame
//     overrun   - sticky: a qualified bit arrived while a word was pending
module serial_word_receiver
    import serial_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = MSB_FIRST_MODE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_en,
    input  logic             serin,
    input  logic             out_ready,
    output logic [WIDTH-1:0] po,
    output logic             out_valid,
    output logic             co,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);

    rx_state_t        state;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             start_acc;
    logic             bit_acc;
    logic [WIDTH-1:0] po_shift;

    // A start is honoured anywhere except over a pending word that is not
    // being transferred this cycle.
    assign start_acc = start && ((state != DONE) || out_ready);

    // A bit counts only in SHIFT and only when no restart is in flight.
    assign bit_acc = (state == SHIFT) && ser_en && !start;

    generate
        if (LSB_FIRST == LSB_FIRST_MODE) begin : g_lsb
            assign po_shift = {serin, po[WIDTH-1:1]};
        end else begin : g_msb
            assign po_shift = {po[WIDTH-2:0], serin};
        end
    endgenerate

    bit_counter #(
        .WIDTH (CW),
        .MAX   (WIDTH - 1)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc),
        .en   (bit_acc),
        .cnt  (cnt),
        .last (cnt_last)
    );

    // Only the terminal flag is needed here; the raw count is kept for debug.
    logic unused_cnt;
    assign unused_cnt = ^cnt;

    always_ff @(posedge clk) begin
        co <= 1'b0;
        if (rst) begin
            state     <= IDLE;
            po        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        po      <= '0;
                        overrun <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        // abort and restart; a bit in this cycle is dropped
                        po      <= '0;
                        overrun <= 1'b0;
                    end else if (ser_en) begin
                        po <= po_shift;
                        if (cnt_last) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            co        <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            state   <= SHIFT;
                            busy    <= 1'b1;
                            po      <= '0;
                            overrun <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (ser_en) begin
                        // word is held; the incoming bit is lost
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
module tb_serial_word_receiver;
    import serial_rx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // shared stimulus for the two WIDTH=8 instances
    logic start8 = 0, en8 = 0, sin8 = 0, rdy8 = 0;
    // separate stimulus for the WIDTH=12 instance
    logic start12 = 0, en12 = 0, sin12 = 0, rdy12 = 0;

    logic [7:0]  po_m, po_l;
    logic [11:0] po_w;
    logic ov_m, co_m, bz_m, or_m;
    logic ov_l, co_l, bz_l, or_l;
    logic ov_w, co_w, bz_w, or_w;

    serial_word_receiver #(.WIDTH(8), .LSB_FIRST(0)) u8m (
        .clk(clk), .rst(rst), .start(start8), .ser_en(en8), .serin(sin8),
        .out_ready(rdy8), .po(po_m), .out_valid(ov_m), .co(co_m),
        .busy(bz_m), .overrun(or_m));

    serial_word_receiver #(.WIDTH(8), .LSB_FIRST(1)) u8l (
        .clk(clk), .rst(rst), .start(start8), .ser_en(en8), .serin(sin8),
        .out_ready(rdy8), .po(po_l), .out_valid(ov_l), .co(co_l),
        .busy(bz_l), .overrun(or_l));

    serial_word_receiver #(.WIDTH(12), .LSB_FIRST(0)) u12 (
        .clk(clk), .rst(rst), .start(start12), .ser_en(en12), .serin(sin12),
        .out_ready(rdy12), .po(po_w), .out_valid(ov_w), .co(co_w),
        .busy(bz_w), .overrun(or_w));

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    logic [7:0]  q_m[$];
    logic [7:0]  q_l[$];
    logic [11:0] q_w[$];
    int co_times[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitors: pop expected word on each completion pulse
    always @(negedge clk) begin
        if (!rst && co_m) begin
            co_times.push_back(cyc);
            if (q_m.size() == 0) chk("u8m unexpected co", 32'(po_m), 32'hFFFF_FFFF);
            else chk("u8m word", 32'(po_m), 32'(q_m.pop_front()));
            chk("u8m valid at co", 32'(ov_m), 32'd1);
        end
        if (!rst && co_l) begin
            if (q_l.size() == 0) chk("u8l unexpected co", 32'(po_l), 32'hFFFF_FFFF);
            else chk("u8l word", 32'(po_l), 32'(q_l.pop_front()));
        end
        if (!rst && co_w) begin
            if (q_w.size() == 0) chk("u12 unexpected co", 32'(po_w), 32'hFFFF_FFFF);
            else chk("u12 word", 32'(po_w), 32'(q_w.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive 8 bits, first bit = w[7]; optional idle gap cycles mid-frame
    task automatic send8(input logic [7:0] w, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            if (gap && (i == 3 || i == 1)) begin
                en8 = 0; sin8 = 1; step();
            end
            en8 = 1; sin8 = w[i]; step();
        end
        en8 = 0; sin8 = 0;
    endtask

    task automatic send12(input logic [11:0] w);
        for (int i = 11; i >= 0; i--) begin
            en12 = 1; sin12 = w[i]; step();
        end
        en12 = 0; sin12 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step();
        chk("reset po", 32'(po_m), 32'd0);
        chk("reset out_valid", 32'(ov_m), 32'd0);
        chk("reset co", 32'(co_m), 32'd0);
        chk("reset busy", 32'(bz_m), 32'd0);
        chk("reset overrun", 32'(or_m), 32'd0);
        rst = 0;

        // ser_en in IDLE is ignored
        en8 = 1; sin8 = 1; step(); step(); en8 = 0;
        chk("idle ignores ser_en", 32'(bz_m), 32'd0);

        // basic frame 1,0,1,1,0,0,1,0 with gaps; MSB -> B2, LSB -> 4D
        q_m.push_back(8'hB2); q_l.push_back(8'h4D);
        start8 = 1; step(); start8 = 0;
        chk("busy in shift", 32'(bz_m), 32'd1);
        send8(8'b1011_0010, 1'b1);
        chk("done valid", 32'(ov_m), 32'd1);
        chk("done busy", 32'(bz_m), 32'd0);

        // back-pressure: 5 cycles of bits while pending
        en8 = 1;
        for (int i = 0; i < 5; i++) begin sin8 = i[0]; step(); end
        en8 = 0;
        chk("bp po msb stable", 32'(po_m), 32'hB2);
        chk("bp po lsb stable", 32'(po_l), 32'h4D);
        chk("bp overrun", 32'(or_m), 32'd1);
        chk("bp valid held", 32'(ov_m), 32'd1);
        // start without ready is ignored
        start8 = 1; step(); start8 = 0;
        chk("start ignored in done", 32'(po_m), 32'hB2);
        rdy8 = 1; step(); rdy8 = 0;
        chk("transfer valid falls", 32'(ov_m), 32'd0);
        chk("overrun sticky in idle", 32'(or_m), 32'd1);
        start8 = 1; step(); start8 = 0;
        chk("start clears overrun", 32'(or_m), 32'd0);

        // abort: 5 bits, then start with serin=1, then 8 fresh bits
        for (int i = 0; i < 5; i++) begin en8 = 1; sin8 = 1; step(); end
        start8 = 1; en8 = 1; sin8 = 1; step(); start8 = 0; en8 = 0;
        chk("abort clears po", 32'(po_m), 32'd0);
        q_m.push_back(8'h69); q_l.push_back(8'h96);
        for (int i = 7; i >= 1; i--) begin
            en8 = 1; sin8 = 1'((8'h69 >> i) & 1); step();
        end
        en8 = 0;
        chk("abort 7 bits not done", 32'(ov_m), 32'd0);
        en8 = 1; sin8 = 1'b1; step(); en8 = 0;
        chk("abort 8th bit done", 32'(ov_m), 32'd1);
        rdy8 = 1; step(); rdy8 = 0;

        // back-to-back at full throughput
        co_times.delete();
        rdy8 = 1;
        q_m.push_back(8'hA5); q_l.push_back(8'hA5);
        q_m.push_back(8'h3C); q_l.push_back(8'h3C);
        start8 = 1; step(); start8 = 0;
        send8(8'hA5, 1'b0);
        start8 = 1; step(); start8 = 0;
        send8(8'h3C, 1'b0);
        step();
        rdy8 = 0;
        step();
        chk("b2b co count", 32'(co_times.size()), 32'd2);
        if (co_times.size() == 2)
            chk("b2b co spacing", 32'(co_times[1] - co_times[0]), 32'd9);
        chk("b2b no overrun", 32'(or_m), 32'd0);

        // WIDTH=12: reset mid-frame
        start12 = 1; step(); start12 = 0;
        for (int i = 0; i < 5; i++) begin en12 = 1; sin12 = 1; step(); end
        en12 = 0;
        rst = 1; step(); rst = 0;
        chk("rst mid po", 32'(po_w), 32'd0);
        chk("rst mid busy", 32'(bz_w), 32'd0);
        chk("rst mid state", 32'(u12.state), 32'(IDLE));

        // reset while DONE with overrun set
        q_w.push_back(12'hF0A);
        start12 = 1; step(); start12 = 0;
        send12(12'hF0A);
        chk("w12 valid", 32'(ov_w), 32'd1);
        en12 = 1; step(); en12 = 0;
        chk("w12 overrun", 32'(or_w), 32'd1);
        rst = 1; step(); rst = 0;
        chk("rst done po", 32'(po_w), 32'd0);
        chk("rst done valid", 32'(ov_w), 32'd0);
        chk("rst done overrun", 32'(or_w), 32'd0);
        chk("rst done co", 32'(co_w), 32'd0);
        chk("rst done state", 32'(u12.state), 32'(IDLE));

        // fresh 12-bit frame
        q_w.push_back(12'hF0A);
        start12 = 1; step(); start12 = 0;
        send12(12'hF0A);
        chk("w12 fresh po", 32'(po_w), 32'hF0A);
        rdy12 = 1; step(); rdy12 = 0;
        chk("w12 transfer", 32'(ov_w), 32'd0);

        step(); step();
        chk("u8m queue drained", 32'(q_m.size()), 32'd0);
        chk("u8l queue drained", 32'(q_l.size()), 32'd0);
        chk("u12 queue drained", 32'(q_w.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
